// File: rtl/write_back_stage.sv
// Write-back stage: selects ALU result or load-formatted memory data, holds it under
// register-file busy backpressure, then writes the register file and counts retirements.
// Latency: 1 cycle from accept to wb_valid. Backpressure: rf_busy stalls the held entry, in_ready falls.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid / in_ready / flush     upstream handshake; flush kills the incoming instruction
//   alu_res, dm_data, wb_sel,
//   ld_mode, dest, reg_we           incoming instruction fields
//   rf_busy                         register-file write port unavailable this cycle
//   rf_we, rf_addr, rf_data         register-file write port
//   wb_valid                        stage holds a valid instruction
//   fwd_valid, fwd_dest, fwd_data   forwarding port taken straight from the held entry
//   retire_count                    saturating count of committed instructions
module write_back_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic [DATA_W-1:0]     dm_data,
    input  logic                  wb_sel,
    input  logic [1:0]            ld_mode,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  reg_we,
    input  logic                  rf_busy,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic                  wb_valid,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retire_count
);

    logic              stored_we;
    logic [DATA_W-1:0] fmt_data;
    logic [DATA_W-1:0] result;
    logic              commit;
    logic              accept;
    logic              zero_dest;

    // Load formatting: the low byte is kept, upper bits come from the word,
    // the byte sign bit, or zero. Mode 11 falls through to word.
    always_comb begin
        fmt_data = dm_data;
        case (ld_mode)
            2'b01: begin
                for (int i = 8; i < DATA_W; i++) begin
                    fmt_data[i] = dm_data[7];
                end
            end
            2'b10: begin
                for (int i = 8; i < DATA_W; i++) begin
                    fmt_data[i] = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign result = wb_sel ? fmt_data : alu_res;

    assign commit   = wb_valid & ~rf_busy;
    assign in_ready = ~wb_valid | commit;
    assign accept   = in_valid & in_ready & ~flush;

    // Register 0 is hard-wired when ZERO_REG is set: never written, never forwarded.
    assign zero_dest = (ZERO_REG != 0) && (rf_addr == '0);

    assign rf_we     = commit & stored_we & ~zero_dest;
    assign fwd_valid = wb_valid & stored_we & ~zero_dest;
    assign fwd_dest  = rf_addr;
    assign fwd_data  = rf_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            stored_we    <= 1'b0;
            rf_addr      <= '0;
            rf_data      <= '0;
            retire_count <= '0;
        end else begin
            // A new entry may replace the committing one on the same edge.
            if (accept) begin
                wb_valid  <= 1'b1;
                rf_data   <= result;
                rf_addr   <= dest;
                stored_we <= reg_we;
            end else if (commit) begin
                wb_valid <= 1'b0;
            end

            // Counts every commit, writing or not; sticks at all-ones.
            if (commit && (retire_count != {CNT_W{1'b1}})) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule
